// File: rtl/mem_port_arbiter.sv
// Shares the single unified memory port between the CPU and a DMA/debug loader.
// Round-robin arbitration, bounded DMA burst lock, and address checking before the RAM.
module mem_port_arbiter #(
  parameter int RAM_SIZE_BIT = 8,
  parameter int LOCK_MAX     = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_gnt,
  output logic [31:0] cpu_rdata,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [31:0] dma_addr,
  input  logic [31:0] dma_wdata,
  input  logic        dma_lock,
  output logic        dma_gnt,
  output logic [31:0] dma_rdata,
  output logic [31:0] Address,
  output logic [31:0] Write_data,
  output logic        MemRead,
  output logic        MemWrite,
  input  logic [31:0] Mem_data,
  output logic        addr_err
);
  localparam int CW = $clog2(LOCK_MAX + 1);

  typedef enum logic [1:0] {IDLE, GNT_CPU, GNT_DMA} state_t;

  state_t        state, state_nxt;
  logic          last, last_nxt;  // 1 = DMA was granted last
  logic [CW-1:0] lock_cnt, lock_cnt_nxt;
  logic          lock_win;

  assign lock_win = dma_lock && (lock_cnt < CW'(LOCK_MAX));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      last     <= 1'b1;
      lock_cnt <= '0;
    end else begin
      state    <= state_nxt;
      last     <= last_nxt;
      lock_cnt <= lock_cnt_nxt;
    end
  end

  // Grant states always fall back to IDLE, so every access takes two cycles.
  always_comb begin
    state_nxt    = IDLE;
    last_nxt     = last;
    lock_cnt_nxt = lock_cnt;
    if (state == IDLE) begin
      if (cpu_req && dma_req) begin
        if (lock_win) begin
          state_nxt    = GNT_DMA;
          lock_cnt_nxt = lock_cnt + CW'(1);
        end else if (last) begin
          state_nxt = GNT_CPU;
        end else begin
          state_nxt = GNT_DMA;
        end
      end else if (cpu_req) begin
        state_nxt = GNT_CPU;
      end else if (dma_req) begin
        state_nxt = GNT_DMA;
      end
    end
    if (state_nxt == GNT_CPU) last_nxt = 1'b0;
    if (state_nxt == GNT_DMA) last_nxt = 1'b1;
    if (state_nxt == GNT_CPU || !dma_lock) lock_cnt_nxt = '0;
  end

  logic        sel_cpu, sel_dma, gnt, addr_ok, sel_we;
  logic [31:0] sel_addr, sel_wdata, rd;

  assign sel_cpu   = (state == GNT_CPU);
  assign sel_dma   = (state == GNT_DMA);
  assign gnt       = sel_cpu | sel_dma;
  assign sel_addr  = sel_dma ? dma_addr  : cpu_addr;
  assign sel_wdata = sel_dma ? dma_wdata : cpu_wdata;
  assign sel_we    = sel_dma ? dma_we    : cpu_we;

  // Rejected accesses still complete the handshake but never strobe the RAM.
  assign addr_ok    = (sel_addr[1:0] == 2'b00) && ((sel_addr >> (RAM_SIZE_BIT + 2)) == 32'd0);
  assign Address    = gnt ? sel_addr  : 32'd0;
  assign Write_data = gnt ? sel_wdata : 32'd0;
  assign MemWrite   = gnt && addr_ok && sel_we;
  assign MemRead    = gnt && addr_ok && !sel_we;
  assign addr_err   = gnt && !addr_ok;
  assign rd         = MemRead ? Mem_data : 32'd0;
  assign cpu_gnt    = sel_cpu;
  assign dma_gnt    = sel_dma;
  assign cpu_rdata  = sel_cpu ? rd : 32'd0;
  assign dma_rdata  = sel_dma ? rd : 32'd0;
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter and sequencer for the single-port unified instruction/data memory of the multi-cycle MIPS CPU. It shares the one memory port between the CPU (fetch and load/store) and a DMA/debug loader port. It grants at most one access per grant cycle, uses round-robin priority with a bounded DMA burst lock, and blocks misaligned or out-of-range accesses before they reach the RAM.

## Interface
- `RAM_SIZE_BIT`, default 8: word-index width of the memory. Valid byte addresses are 0 to 4*2^RAM_SIZE_BIT-1.
- `LOCK_MAX`, default 16: maximum consecutive locked DMA grants while the CPU is waiting.
- `clk` in 1: clock. All state updates on the rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `cpu_req` in 1: CPU access request. Held until `cpu_gnt`.
- `cpu_we` in 1: 1 = write, 0 = read.
- `cpu_addr` in 32: byte address.
- `cpu_wdata` in 32: write data.
- `cpu_gnt` out 1: CPU access performed this cycle.
- `cpu_rdata` out 32: read data. Valid while `cpu_gnt`=1.
- `dma_req`, `dma_we`, `dma_addr`, `dma_wdata`: DMA equivalents of the CPU request inputs.
- `dma_lock` in 1: request burst priority for DMA.
- `dma_gnt` out 1: DMA access performed this cycle.
- `dma_rdata` out 32: DMA read data. Valid while `dma_gnt`=1.
- `Address` out 32: memory address.
- `Write_data` out 32: memory write data.
- `MemRead` out 1: memory read strobe.
- `MemWrite` out 1: memory write strobe. The RAM writes on the rising edge that ends the cycle.
- `Mem_data` in 32: combinational read data from the memory.
- `addr_err` out 1: the granted access was rejected this cycle.

## Operation
- FSM states: IDLE, GNT_CPU, GNT_DMA. Reset and default state is IDLE.
- Transitions out of IDLE, evaluated from the live `*_req` inputs:
  - Neither request: stay in IDLE.
  - One request: go to that requester's grant state.
  - Both requests: winner is decided by priority (below).
- GNT_CPU and GNT_DMA always return to IDLE after one cycle. There is no back-to-back grant.
- Priority when both requests are present:
  - DMA wins if `dma_lock`=1 and `lock_cnt` < LOCK_MAX.
  - Otherwise the winner is the requester not recorded in `last`.
- `last` register:
  - Reset value is DMA, so the CPU wins the first tie.
  - Updated to the granted requester on every grant.
- `lock_cnt` register (width clog2(LOCK_MAX+1), saturating):
  - Increments on a DMA grant won via lock while `cpu_req`=1.
  - Clears on any CPU grant, or on any cycle with `dma_lock`=0.
  - Reset value is 0.
- In a grant state, the granted requester's `addr`/`we`/`wdata` drive the memory combinationally:
  - `Address` = addr, `Write_data` = wdata.
  - `MemWrite` = we, `MemRead` = !we.
  - That requester's `rdata` = `Mem_data` when reading, 0 when writing.
- Address check: an access is rejected if addr[1:0]≠0, or if addr[31:RAM_SIZE_BIT+2]≠0. On rejection:
  - `MemRead`=`MemWrite`=0.
  - `rdata`=0.
  - `addr_err`=1.
  - `gnt` still asserts, so the requester completes and is not retried.
- Outputs in IDLE, and the non-granted requester's outputs: `Address`=0, `Write_data`=0, `MemRead`=0, `MemWrite`=0, `gnt`=0, `rdata`=0, `addr_err`=0.
- Requester contract:
  - Hold `req` and all request fields stable from assertion through the `gnt` cycle.
  - `req` high in the cycle after `gnt` is a new request.
  - Dropping `req` before `gnt` withdraws the request. If the grant state was already entered, that cycle still strobes with the current fields.

## Timing
- Request asserted in IDLE in cycle N produces `gnt` in cycle N+1, with read data valid in N+1. A write commits at the end of N+1.
- Minimum 2 cycles per access, so peak bandwidth is 0.5 access/cycle.
- Worst-case CPU latency with DMA locked: 2*LOCK_MAX+2 cycles.
- `reset` asserted in any state:
  - Immediately forces IDLE, `last`=DMA, `lock_cnt`=0.
  - All outputs go to 0 asynchronously. No memory strobe is issued during reset.
  - An in-flight grant is aborted with no `gnt` retry.
- `gnt` is Moore-decoded from state. Memory-side fields are combinational from the granted requester's inputs.

## Test plan
- Single CPU read: `cpu_req`=1, addr=0x0 after reset. Required: `cpu_gnt` one cycle later, `MemRead`=1, `Address`=0, `cpu_rdata`=0x20040005 (the `addi $a0,$zero,5` word).
- DMA write then CPU read: DMA writes 0xDEADBEEF to 0x80, then the CPU reads 0x80. Required: `MemWrite` exactly one cycle, then `cpu_rdata`=0xDEADBEEF.
- Simultaneous requests, no lock, held for 4 accesses each. Required grant order CPU, DMA, CPU, DMA… with one IDLE cycle between grants.
- `dma_lock`=1, LOCK_MAX=4, both requesting continuously. Required: 4 DMA grants, then 1 CPU grant, then DMA again. `lock_cnt` returns to 0 after the CPU grant.
- CPU read of 0x402 (misaligned) and DMA read of 0x400 (out of range, RAM_SIZE_BIT=8). Required for each: `gnt`=1, `addr_err`=1, `MemRead`=0, `rdata`=0.
- `reset` pulsed during GNT_DMA for a write. Required: `MemWrite` drops immediately, memory is unchanged, and after reset release a tie goes to the CPU.
